// File: rtl/mem_pkg.sv
// Shared definitions for data_memory_pipe: access-size encodings, store lane
// masks, store-data replication and load extension.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_SIZE_BYTE = 2'd0,
        MEM_SIZE_HALF = 2'd1,
        MEM_SIZE_WORD = 2'd2,
        MEM_SIZE_RSVD = 2'd3
    } mem_size_e;

    localparam int unsigned MEM_READ_LATENCY_MIN = 1;
    localparam int unsigned MEM_READ_LATENCY_MAX = 4;

    function automatic logic [3:0] mem_lane_mask(input mem_size_e size, input logic [1:0] offset);
        logic [3:0] mask;
        mask = '0;
        case (size)
            MEM_SIZE_BYTE: mask = 4'b0001 << offset;
            MEM_SIZE_HALF: mask = 4'b0011 << offset;
            default:       mask = 4'b1111;
        endcase
        return mask;
    endfunction

    function automatic logic [31:0] mem_store_data(input mem_size_e size, input logic [31:0] wd);
        logic [31:0] data;
        data = '0;
        case (size)
            MEM_SIZE_BYTE: data = {4{wd[7:0]}};
            MEM_SIZE_HALF: data = {2{wd[15:0]}};
            default:       data = wd;
        endcase
        return data;
    endfunction

    function automatic logic [31:0] mem_load_extend(input logic [31:0] word, input mem_size_e size,
                                                    input logic [1:0] offset, input logic zero_ext);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {offset, 3'b000};
        result  = '0;
        case (size)
            MEM_SIZE_BYTE: result = {{24{~zero_ext & shifted[7]}}, shifted[7:0]};
            MEM_SIZE_HALF: result = {{16{~zero_ext & shifted[15]}}, shifted[15:0]};
            default:       result = word;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mem_array.sv
// 32-bit single-port storage array with per-byte write enables and a
// registered read that only updates on a non-writing access.
module mem_array #(
    parameter int unsigned DEPTH_WORDS = 16384,
    parameter int unsigned INDEX_WIDTH = $clog2(DEPTH_WORDS)
) (
    input  logic                   clock,
    input  logic                   en,
    input  logic [3:0]             wmask,
    input  logic [INDEX_WIDTH-1:0] index,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (en) begin
            for (int unsigned lane = 0; lane < 4; lane++) begin
                if (wmask[lane]) begin
                    mem[index][lane*8 +: 8] <= wdata[lane*8 +: 8];
                end
            end
            if (wmask == '0) begin
                rdata <= mem[index];
            end
        end
    end

endmodule

// File: rtl/data_memory_pipe.sv
// Byte-addressed data memory with valid/ready request channel and an in-order
// response pipeline. Optional misalignment trap: `define MEM_MISALIGN_TRAP_EN.
module data_memory_pipe
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned DEPTH_WORDS  = 16384,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wEn,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [31:0]           req_write_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic                  resp_error
);

    localparam int unsigned INDEX_WIDTH = $clog2(DEPTH_WORDS);
    localparam int unsigned LATENCY =
        (READ_LATENCY < MEM_READ_LATENCY_MIN) ? MEM_READ_LATENCY_MIN :
        (READ_LATENCY > MEM_READ_LATENCY_MAX) ? MEM_READ_LATENCY_MAX : READ_LATENCY;
    localparam int unsigned LAST = LATENCY - 1;

    logic                   advance;
    logic                   accept;
    mem_size_e              size_in;
    mem_size_e              size_eff;
    logic [1:0]             offset_eff;
    logic                   misalign;
    logic [INDEX_WIDTH-1:0] index;
    logic [3:0]             wmask;
    logic [31:0]            wdata;
    logic [31:0]            rdata;
    logic                   unused_addr;

    logic        st_valid  [LATENCY];
    logic        st_error  [LATENCY];
    logic [31:0] st_data_q [LATENCY];
    logic [31:0] st_data   [LATENCY];

    logic        s1_load;
    logic        s1_unsigned;
    mem_size_e   s1_size;
    logic [1:0]  s1_offset;

    assign advance     = !st_valid[LAST] || resp_ready;
    assign req_ready   = advance && reset;
    assign accept      = req_valid && req_ready;
    assign size_in     = mem_size_e'(req_size);
    assign index       = req_address[INDEX_WIDTH+1:2];
    assign unused_addr = ^req_address;

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        misalign   = 1'b0;
        size_eff   = size_in;
        offset_eff = req_address[1:0];
        case (size_in)
            MEM_SIZE_HALF: misalign = req_address[0];
            MEM_SIZE_WORD: misalign = |req_address[1:0];
            MEM_SIZE_RSVD: misalign = 1'b1;
            default:       misalign = 1'b0;
        endcase
    end
`else
    always_comb begin
        misalign   = 1'b0;
        size_eff   = size_in;
        offset_eff = req_address[1:0];
        case (size_in)
            MEM_SIZE_HALF: offset_eff[0] = 1'b0;
            MEM_SIZE_WORD, MEM_SIZE_RSVD: begin
                size_eff   = MEM_SIZE_WORD;
                offset_eff = 2'b00;
            end
            default: ;
        endcase
    end
`endif

    assign wmask = (req_wEn && !misalign) ? mem_lane_mask(size_eff, offset_eff) : '0;
    assign wdata = mem_store_data(size_eff, req_write_data);

    mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .INDEX_WIDTH(INDEX_WIDTH)
    ) u_array (
        .clock (clock),
        .en    (accept),
        .wmask (wmask),
        .index (index),
        .wdata (wdata),
        .rdata (rdata)
    );

    // The array's read register doubles as stage-1 data; only the load
    // selection is kept here and extension happens on the way out of stage 1.
    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_load     <= 1'b0;
            s1_unsigned <= 1'b0;
            s1_size     <= MEM_SIZE_BYTE;
            s1_offset   <= '0;
        end else if (advance) begin
            s1_load     <= accept && !req_wEn;
            s1_unsigned <= req_unsigned;
            s1_size     <= size_eff;
            s1_offset   <= offset_eff;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                st_valid[i]  <= 1'b0;
                st_error[i]  <= 1'b0;
                st_data_q[i] <= '0;
            end
        end else if (advance) begin
            st_valid[0]  <= accept;
            st_error[0]  <= accept && misalign;
            st_data_q[0] <= '0;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                st_valid[i]  <= st_valid[i-1];
                st_error[i]  <= st_error[i-1];
                st_data_q[i] <= st_data[i-1];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < LATENCY; i++) begin
            st_data[i] = st_data_q[i];
        end
        st_data[0] = (st_valid[0] && s1_load && !st_error[0]) ?
                     mem_load_extend(rdata, s1_size, s1_offset, s1_unsigned) : '0;
    end

    assign resp_valid = st_valid[LAST];
    assign resp_data  = st_data[LAST];
`ifdef MEM_MISALIGN_TRAP_EN
    assign resp_error = st_error[LAST];
`else
    assign resp_error = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory_pipe.sv
// Directed bench for data_memory_pipe: a byte-level memory model plus an
// in-order response queue, checked every cycle, with literal expectations.
module tb_data_memory_pipe;

    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 1024;
    localparam int unsigned LAT = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_wEn = 1'b0;
    logic [1:0]    req_size = 2'd0;
    logic          req_unsigned = 1'b0;
    logic [AW-1:0] req_address = '0;
    logic [31:0]   req_write_data = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [31:0]   resp_data;
    logic          resp_error;

    data_memory_pipe #(
        .ADDR_WIDTH(AW),
        .DEPTH_WORDS(DW),
        .READ_LATENCY(LAT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_wEn        (req_wEn),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_address    (req_address),
        .req_write_data (req_write_data),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_error     (resp_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
        logic        has_lit;
        logic [31:0] lit_data;
        logic        lit_err;
    } resp_t;

    resp_t       q[$];
    logic [7:0]  mb [DW*4];
    int          edge_cnt = 0;
    int          accept_cnt = 0;
    int          total = 0;
    int          bad = 0;
    logic        lit_en = 1'b0;
    logic [31:0] lit_data = '0;
    logic        lit_err = 1'b0;

    function automatic resp_t model_access(input logic we, input logic [1:0] sz, input logic uns,
                                           input logic [AW-1:0] addr, input logic [31:0] wd);
        resp_t       r;
        int          base;
        int          off;
        int          nbytes;
        logic        fault;
        logic [31:0] v;
        base   = ((int'(addr) >> 2) % DW) * 4;
        off    = int'(addr) % 4;
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        fault  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        fault = (sz == 2'd3) || (off % nbytes != 0);
`else
        off = off - (off % nbytes);
`endif
        r.data = '0; r.err = fault; r.due = 0;
        r.has_lit = 1'b0; r.lit_data = '0; r.lit_err = 1'b0;
        if (!fault) begin
            if (we) begin
                for (int k = 0; k < nbytes; k++) mb[base+off+k] = wd[8*k +: 8];
            end else begin
                v = '0;
                for (int k = 0; k < nbytes; k++) v[8*k +: 8] = mb[base+off+k];
                if (!uns && nbytes < 4 && v[8*nbytes-1])
                    for (int k = 8*nbytes; k < 32; k++) v[k] = 1'b1;
                r.data = v;
            end
        end
        return r;
    endfunction

    // Model update at the active edge: global stall delays every queued response.
    always @(posedge clock) begin
        int    cur;
        logic  ev;
        resp_t r;
        cur = edge_cnt;
        ev  = (q.size() > 0) && (q[0].due <= cur);
        if (!reset) begin
            q.delete();
        end else begin
            if (ev && resp_ready) void'(q.pop_front());
            else if (ev) foreach (q[i]) q[i].due = q[i].due + 1;
            if (req_valid && (!ev || resp_ready)) begin
                r = model_access(req_wEn, req_size, req_unsigned, req_address, req_write_data);
                r.due      = cur + int'(LAT);
                r.has_lit  = lit_en;
                r.lit_data = lit_data;
                r.lit_err  = lit_err;
                q.push_back(r);
                accept_cnt = accept_cnt + 1;
            end
        end
        edge_cnt = cur + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=0x%08h want=0x%08h", name, edge_cnt, act, exp);
        end
    endtask

    always @(negedge clock) begin
        logic ev;
        logic exp_rdy;
        #1;
        ev      = (q.size() > 0) && (q[0].due <= edge_cnt);
        exp_rdy = reset && (!ev || resp_ready);
        check("req_ready", {31'd0, req_ready}, {31'd0, exp_rdy});
        check("resp_valid", {31'd0, resp_valid}, {31'd0, ev});
        if (ev) begin
            check("resp_data", resp_data, q[0].data);
            check("resp_error", {31'd0, resp_error}, {31'd0, q[0].err});
            if (q[0].has_lit) begin
                check("lit_data", resp_data, q[0].lit_data);
                check("lit_error", {31'd0, resp_error}, {31'd0, q[0].lit_err});
            end
        end
    end

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns, input logic [AW-1:0] addr,
                          input logic [31:0] wd, input logic [31:0] ld, input logic le);
        int start;
        int tries;
        @(negedge clock);
        req_valid = 1'b1; req_wEn = we; req_size = sz; req_unsigned = uns;
        req_address = addr; req_write_data = wd;
        lit_en = 1'b1; lit_data = ld; lit_err = le;
        start = accept_cnt;
        tries = 0;
        do begin
            @(posedge clock); #1;
            tries++;
        end while (accept_cnt == start && tries < 50);
        if (accept_cnt == start) begin
            total++; bad++;
            $display("FAIL accept_timeout addr=0x%04h got=none want=accept", addr);
        end
    endtask

    task automatic idle();
        @(negedge clock);
        req_valid = 1'b0; lit_en = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (q.size() > 0) begin
            total++; bad++;
            $display("FAIL drain_timeout got=%0d pending want=0", q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clock);
        reset = 1'b1;
        do_req(1'b1, 2'd2, 1'b0, 16'h0000, 32'h12345678, 32'h0, 1'b0);
        idle(); drain();

        // Reset held low with a pending store that must not land.
        @(negedge clock);
        reset = 1'b0; req_valid = 1'b1; req_wEn = 1'b1; req_size = 2'd2;
        req_address = 16'h0000; req_write_data = 32'hBAD0BAD0;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("rst_req_ready", {31'd0, req_ready}, 32'd0);
            check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
            @(negedge clock);
        end
        reset = 1'b1; req_valid = 1'b0;

        do_req(1'b0, 2'd2, 1'b0, 16'h0000, 32'h0, 32'h12345678, 1'b0);
        idle(); drain();

        do_req(1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF, 32'h0, 1'b0);
        do_req(1'b0, 2'd0, 1'b0, 16'h0013, 32'h0, 32'hFFFFFFDE, 1'b0);
        do_req(1'b0, 2'd0, 1'b1, 16'h0013, 32'h0, 32'h000000DE, 1'b0);
        do_req(1'b0, 2'd1, 1'b0, 16'h0010, 32'h0, 32'hFFFFBEEF, 1'b0);
        do_req(1'b0, 2'd1, 1'b1, 16'h0012, 32'h0, 32'h0000DEAD, 1'b0);
        idle(); drain();

        do_req(1'b1, 2'd2, 1'b0, 16'h0020, 32'h11223344, 32'h0, 1'b0);
        do_req(1'b1, 2'd0, 1'b0, 16'h0021, 32'hFFFFFFA5, 32'h0, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 16'h0020, 32'h0, 32'h1122A544, 1'b0);
        do_req(1'b1, 2'd1, 1'b0, 16'h0022, 32'h12347788, 32'h0, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 16'h0020, 32'h0, 32'h7788A544, 1'b0);
        idle(); drain();

        do_req(1'b1, 2'd2, 1'b0, 16'h0004, 32'hA0A0A0A4, 32'h0, 1'b0);
        do_req(1'b1, 2'd2, 1'b0, 16'h0008, 32'h80808088, 32'h0, 1'b0);
        idle(); drain();

        fork
            begin
                do_req(1'b0, 2'd2, 1'b0, 16'h0000, 32'h0, 32'h12345678, 1'b0);
                do_req(1'b0, 2'd2, 1'b0, 16'h0004, 32'h0, 32'hA0A0A0A4, 1'b0);
                do_req(1'b0, 2'd2, 1'b0, 16'h0008, 32'h0, 32'h80808088, 1'b0);
                do_req(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0);
                do_req(1'b0, 2'd2, 1'b0, 16'h0020, 32'h0, 32'h7788A544, 1'b0);
                idle();
            end
            begin
                int n;
                n = 0;
                do begin
                    @(negedge clock); #2;
                    n++;
                end while (!resp_valid && n < 50);
                check("first_latency", n, 32'd4);
                @(negedge clock); #2;
                check("second_data", resp_data, 32'hA0A0A0A4);
                resp_ready = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    @(negedge clock); #2;
                    check("stall_req_ready", {31'd0, req_ready}, 32'd0);
                    check("stall_resp_valid", {31'd0, resp_valid}, 32'd1);
                    check("stall_resp_data", resp_data, 32'hA0A0A0A4);
                end
                resp_ready = 1'b1;
            end
        join
        drain();

        do_req(1'b1, 2'd2, 1'b0, 16'h1000, 32'hCAFEF00D, 32'h0, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 16'h0000, 32'h0, 32'hCAFEF00D, 1'b0);
        idle(); drain();

`ifdef MEM_MISALIGN_TRAP_EN
        do_req(1'b1, 2'd2, 1'b0, 16'h0002, 32'h55667788, 32'h0, 1'b1);
        do_req(1'b0, 2'd2, 1'b0, 16'h0000, 32'h0, 32'hCAFEF00D, 1'b0);
        do_req(1'b0, 2'd1, 1'b0, 16'h0011, 32'h0, 32'h0, 1'b1);
        do_req(1'b0, 2'd3, 1'b1, 16'h0020, 32'h0, 32'h0, 1'b1);
`else
        do_req(1'b1, 2'd2, 1'b0, 16'h0002, 32'h55667788, 32'h0, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 16'h0000, 32'h0, 32'h55667788, 1'b0);
        do_req(1'b0, 2'd1, 1'b0, 16'h0011, 32'h0, 32'hFFFFBEEF, 1'b0);
        do_req(1'b0, 2'd3, 1'b1, 16'h0020, 32'h0, 32'h7788A544, 1'b0);
`endif
        idle(); drain();

        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
